fifo_wr_arbiter: RTL and testbench

- Write-side scheduler that shares the async FIFO write port (winc/wdata, gated by wfull) among NREQ requesters in the wclk domain.
- Arbitration is round-robin at packet granularity. A granted requester keeps the port until it transfers a beat marked last, or until an idle timeout releases it.
- The block sits directly in front of the FIFO top and drives its winc and wdata.

---
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-granular scheduler sharing one async-FIFO write port among NREQ requesters.
// Latency: grant one cycle after req; beats then pass combinationally (winc/ack/wdata) from held grant.
// Backpressure: wfull stalls the owner's beat without releasing the grant or counting toward the idle timeout.
module fifo_wr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       last,
    input  logic [NREQ*WIDTH-1:0] wdata_in,
    input  logic                  wfull,
    output logic                  winc,
    output logic [WIDTH-1:0]      wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [IDW-1:0]        owner,
    output logic                  busy,
    output logic                  abort
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [7:0] IDLE_LIMIT = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [IDW-1:0]    owner_q, owner_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [7:0]        idle_cnt_q, idle_cnt_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              abort_q, abort_d;

    logic [IDW-1:0]    pick;
    logic [IDW-1:0]    pick_next;
    logic              own_req;
    logic              own_last;
    logic              xfer;

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        logic found;
        int   cand;
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = (int'(rr_ptr_q) + i) % NREQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = IDW'(cand);
            end
        end
    end

    assign pick_next = (int'(pick) == NREQ - 1) ? '0 : pick + IDW'(1);

    assign own_req  = req[owner_q];
    assign own_last = last[owner_q];
    assign xfer     = (state_q == S_BURST) && own_req && !wfull;

    assign winc  = xfer;
    assign busy  = (state_q == S_BURST);
    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign abort = abort_q;

    always_comb begin
        ack          = '0;
        ack[owner_q] = xfer;
    end

    always_comb begin
        wdata = '0;
        if (state_q == S_BURST) begin
            wdata = wdata_in[int'(owner_q)*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        idle_cnt_d = idle_cnt_q;
        gnt_d      = gnt_q;
        abort_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d    = pick;
                    gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << pick;
                    rr_ptr_d   = pick_next;
                    idle_cnt_d = '0;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                if (own_req) begin
                    idle_cnt_d = '0;
                    if (xfer && own_last) begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end else if (idle_cnt_q == IDLE_LIMIT) begin
                    // Owner stays visible during the abort cycle so downstream can tag the dropped packet.
                    state_d    = S_IDLE;
                    gnt_d      = '0;
                    abort_d    = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            gnt_q      <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            idle_cnt_q <= idle_cnt_d;
            gnt_q      <= gnt_d;
            abort_q    <= abort_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed stall/timeout/reset sequences, randomized run vs. packet-level model.
module tb_fifo_wr_arbiter;

    localparam int WIDTH   = 8;
    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 15;

    logic                  wclk = 1'b0;
    logic                  wrst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0]       last;
    logic [NREQ*WIDTH-1:0] wdata_in;
    logic                  wfull;
    logic                  winc;
    logic [WIDTH-1:0]      wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [IDW-1:0]        owner;
    logic                  busy;
    logic                  abort;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .req(req), .last(last), .wdata_in(wdata_in),
        .wfull(wfull), .winc(winc), .wdata(wdata), .gnt(gnt), .ack(ack),
        .owner(owner), .busy(busy), .abort(abort)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [NREQ-1:0] req;
        logic [NREQ-1:0] last;
        logic            wfull;
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic            winc;
        logic            abort;
        logic [IDW-1:0]  owner;
    } vec_t;

    vec_t tbl[14];

    function automatic vec_t mk(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic f,
                                input logic [NREQ-1:0] g, input logic b, input logic w,
                                input logic a, input logic [IDW-1:0] o);
        vec_t v;
        v.req = r; v.last = l; v.wfull = f;
        v.gnt = g; v.busy = b; v.winc = w; v.abort = a; v.owner = o;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Apply one cycle of inputs on the falling edge, then let combinational outputs settle.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic f);
        @(negedge wclk);
        req   = r;
        last  = l;
        wfull = f;
        for (int i = 0; i < NREQ; i++) wdata_in[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        #1;
    endtask

    task automatic exp_out(input string tag, input logic [NREQ-1:0] e_gnt, input logic e_busy,
                           input logic e_winc, input logic e_abort, input logic [IDW-1:0] e_owner);
        logic [NREQ-1:0]  e_ack;
        logic [WIDTH-1:0] e_wd;
        e_ack = e_winc ? e_gnt : '0;
        e_wd  = e_busy ? wdata_in[int'(e_owner)*WIDTH +: WIDTH] : '0;
        chk({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
        chk({tag, ".busy"},  32'(busy),  32'(e_busy));
        chk({tag, ".winc"},  32'(winc),  32'(e_winc));
        chk({tag, ".ack"},   32'(ack),   32'(e_ack));
        chk({tag, ".abort"}, 32'(abort), 32'(e_abort));
        chk({tag, ".owner"}, 32'(owner), 32'(e_owner));
        chk({tag, ".wdata"}, 32'(wdata), 32'(e_wd));
    endtask

    task automatic do_reset();
        @(negedge wclk);
        wrst_n = 1'b0;
        req = '0; last = '0; wfull = 1'b0; wdata_in = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
    endtask

    // Reference model: holder of the port, last served index, consecutive quiet cycles.
    int m_holder, m_last_srv, m_quiet, m_owner;
    bit m_abort;

    task automatic model_reset();
        m_holder = -1; m_last_srv = NREQ - 1; m_quiet = 0; m_owner = 0; m_abort = 0;
    endtask

    task automatic model_check(input int cyc);
        logic [NREQ-1:0] g;
        logic            w;
        g = (m_holder >= 0) ? (NREQ'(1) << m_holder) : '0;
        w = (m_holder >= 0) && req[m_holder] && !wfull;
        exp_out($sformatf("rand%0d", cyc), g, m_holder >= 0, w, m_abort, IDW'(m_owner));
    endtask

    task automatic model_advance();
        bit wrote;
        m_abort = 0;
        if (m_holder < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last_srv + k) % NREQ;
                if (m_holder < 0 && req[c]) begin
                    m_holder = c; m_last_srv = c; m_owner = c; m_quiet = 0;
                end
            end
        end else begin
            wrote = req[m_holder] && !wfull;
            if (wrote && last[m_holder]) begin
                m_holder = -1;
            end else if (!req[m_holder]) begin
                m_quiet++;
                if (m_quiet == TIMEOUT) begin
                    m_holder = -1;
                    m_abort  = 1;
                end
            end else begin
                m_quiet = 0;
            end
        end
    endtask

    initial begin
        int density;
        wrst_n = 1'b0;
        req = '0; last = '0; wfull = 1'b0; wdata_in = '0;

        // 3-beat packet from requester 0, then 1-beat packets from everyone in round-robin order.
        tbl[0]  = mk(4'b0001, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd0);
        tbl[1]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 0, 2'd0);
        tbl[2]  = mk(4'b0001, 4'b0000, 0, 4'b0001, 1, 1, 0, 2'd0);
        tbl[3]  = mk(4'b0001, 4'b0001, 0, 4'b0001, 1, 1, 0, 2'd0);
        tbl[4]  = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd0);
        tbl[5]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0, 2'd0);
        tbl[6]  = mk(4'b1111, 4'b1111, 0, 4'b0010, 1, 1, 0, 2'd1);
        tbl[7]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0, 2'd1);
        tbl[8]  = mk(4'b1111, 4'b1111, 0, 4'b0100, 1, 1, 0, 2'd2);
        tbl[9]  = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0, 2'd2);
        tbl[10] = mk(4'b1111, 4'b1111, 0, 4'b1000, 1, 1, 0, 2'd3);
        tbl[11] = mk(4'b1111, 4'b1111, 0, 4'b0000, 0, 0, 0, 2'd3);
        tbl[12] = mk(4'b1111, 4'b1111, 0, 4'b0001, 1, 1, 0, 2'd0);
        tbl[13] = mk(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 2'd0);

        repeat (2) @(negedge wclk);
        #1;
        exp_out("reset", '0, 0, 0, 0, '0);
        @(negedge wclk);
        wrst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].last, tbl[i].wfull);
            exp_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].busy, tbl[i].winc, tbl[i].abort, tbl[i].owner);
        end

        // Owner 2 stalled by wfull for 5 cycles, with last already presented during the stall.
        step(4'b0100, 4'b0000, 0); exp_out("stall.arb", 4'b0000, 0, 0, 0, 2'd0);
        step(4'b0100, 4'b0000, 0); exp_out("stall.b1", 4'b0100, 1, 1, 0, 2'd2);
        repeat (5) begin
            step(4'b0100, 4'b0100, 1); exp_out("stall.full", 4'b0100, 1, 0, 0, 2'd2);
        end
        step(4'b0100, 4'b0100, 0); exp_out("stall.end", 4'b0100, 1, 1, 0, 2'd2);
        step(4'b0000, 4'b0000, 0); exp_out("stall.idle", 4'b0000, 0, 0, 0, 2'd2);

        // Owner 1 silent for TIMEOUT cycles while requester 2 waits.
        step(4'b0010, 4'b0000, 0); exp_out("to.arb", 4'b0000, 0, 0, 0, 2'd2);
        step(4'b0010, 4'b0000, 0); exp_out("to.b1", 4'b0010, 1, 1, 0, 2'd1);
        for (int i = 1; i <= TIMEOUT; i++) begin
            step(4'b0100, 4'b0100, 0);
            exp_out($sformatf("to.quiet%0d", i), 4'b0010, 1, 0, 0, 2'd1);
        end
        step(4'b0100, 4'b0100, 0); exp_out("to.abort", 4'b0000, 0, 0, 1, 2'd1);
        step(4'b0100, 4'b0100, 0); exp_out("to.next", 4'b0100, 1, 1, 0, 2'd2);
        step(4'b0000, 4'b0000, 0); exp_out("to.idle", 4'b0000, 0, 0, 0, 2'd2);

        // One cycle short of the timeout, twice, proves the counter clears on reassertion.
        step(4'b0010, 4'b0000, 0); exp_out("nto.arb", 4'b0000, 0, 0, 0, 2'd2);
        for (int j = 0; j < 2; j++) begin
            for (int i = 1; i < TIMEOUT; i++) begin
                step(4'b0000, 4'b0000, 0);
                exp_out($sformatf("nto.quiet%0d_%0d", j, i), 4'b0010, 1, 0, 0, 2'd1);
            end
            step(4'b0010, (j == 1) ? 4'b0010 : 4'b0000, 0);
            exp_out($sformatf("nto.beat%0d", j), 4'b0010, 1, 1, 0, 2'd1);
        end
        step(4'b0000, 4'b0000, 0); exp_out("nto.idle", 4'b0000, 0, 0, 0, 2'd1);

        // Reset mid-burst, then the pointer restarts at 0.
        step(4'b0100, 4'b0000, 0); exp_out("rst.arb", 4'b0000, 0, 0, 0, 2'd1);
        step(4'b0100, 4'b0000, 0); exp_out("rst.b1", 4'b0100, 1, 1, 0, 2'd2);
        wrst_n = 1'b0;
        #1;
        exp_out("rst.async", 4'b0000, 0, 0, 0, 2'd0);
        req = '0;
        @(negedge wclk);
        wrst_n = 1'b1;
        step(4'b1000, 4'b1000, 0); exp_out("rst.arb3", 4'b0000, 0, 0, 0, 2'd0);
        step(4'b1000, 4'b1000, 0); exp_out("rst.own3", 4'b1000, 1, 1, 0, 2'd3);
        step(4'b1001, 4'b1001, 0); exp_out("rst.arb0", 4'b0000, 0, 0, 0, 2'd3);
        step(4'b1001, 4'b1001, 0); exp_out("rst.own0", 4'b0001, 1, 1, 0, 2'd0);
        step(4'b0000, 4'b0000, 0); exp_out("rst.idle", 4'b0000, 0, 0, 0, 2'd0);

        // Randomized traffic with varying request density so timeouts and contention both occur.
        do_reset();
        model_reset();
        density = 2;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            logic [NREQ-1:0] r, l;
            logic            f;
            int              pct;
            if (cyc % 80 == 0) density = $urandom_range(0, 3);
            pct = (density == 0) ? 5 : (density == 1) ? 30 : (density == 2) ? 70 : 95;
            for (int i = 0; i < NREQ; i++) begin
                r[i] = ($urandom_range(0, 99) < pct);
                l[i] = ($urandom_range(0, 99) < 30);
            end
            f = ($urandom_range(0, 99) < 15);
            step(r, l, f);
            model_check(cyc);
            model_advance();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
